// File: rtl/sat_sched_pkg.sv
// Shared types, default widths and the symmetric saturate helper for sat_rr_sched.
// Contents:
//   - default width constants (lanes, input/output sample, counter)
//   - lane_id_t      : lane index type at the default lane count
//   - out_state_e    : output register state {EMPTY, FULL}
//   - sat_res_t      : saturate result (clip flag + value)
//   - sym_sat()      : symmetric clip to +/-(2^(out_w-1)-1)
package sat_sched_pkg;

  localparam int unsigned N_REQ_DEF = 4;
  localparam int unsigned IN_W_DEF  = 9;
  localparam int unsigned OUT_W_DEF = 8;
  localparam int unsigned CNT_W_DEF = 16;
  localparam int unsigned LANE_W    = $clog2(N_REQ_DEF);

  typedef logic [LANE_W-1:0] lane_id_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_e;

  typedef struct packed {
    logic               clip;
    logic signed [31:0] val;
  } sat_res_t;

  // Symmetric saturation; the most negative code also clips so the range is balanced.
  function automatic sat_res_t sym_sat(input logic signed [31:0] x,
                                       input int unsigned out_w);
    logic signed [31:0] lim;
    sat_res_t           r;
    lim    = (32'sd1 <<< (out_w - 1)) - 32'sd1;
    r.val  = x;
    r.clip = 1'b0;
    if (x > lim) begin
      r.val  = lim;
      r.clip = 1'b1;
    end else if (x < -lim) begin
      r.val  = -lim;
      r.clip = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requesting lane at or after ptr_i, with wrap.
// Ports:
//   req_i      in  N_REQ  request vector
//   en_i       in  1      grant permitted this cycle
//   ptr_i      in  ID_W   search start lane
//   gnt_o      out N_REQ  one-hot grant (zero when none)
//   gnt_idx_o  out ID_W   granted lane index
//   gnt_any_o  out 1      a grant was issued
module rr_arbiter #(
  parameter  int unsigned N_REQ = 4,
  localparam int unsigned ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic             en_i,
  input  logic [ID_W-1:0]  ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]  gnt_idx_o,
  output logic             gnt_any_o
);

  logic [ID_W-1:0] idx;
  logic            found;

  // Walk lanes starting at the pointer; first hit wins.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    gnt_any_o = 1'b0;
    idx       = '0;
    found     = 1'b0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = ID_W'((32'(ptr_i) + k) % N_REQ);
      if (en_i && !found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        gnt_idx_o  = idx;
        found      = 1'b1;
      end
    end
    gnt_any_o = found;
  end

endmodule

// File: rtl/sat_rr_sched.sv
// Round-robin scheduler sharing one symmetric saturation stage across FFT output lanes.
// Optional feature macro: SAT_STATS_EN (adds CNT_W, sat_cnt_clr, sat_cnt and the clip counter).
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req_valid/req_data  per-lane valid and signed IN_W sample
//   req_ready           per-lane accept (one-hot or zero), combinational
//   out_valid/out_data  held saturated sample
//   out_id/out_sat      lane of held sample, clip flag
//   out_ready           sink accepts
//   sat_cnt_clr/sat_cnt clip event counter clear / value (SAT_STATS_EN)
module sat_rr_sched
  import sat_sched_pkg::*;
#(
  parameter  int unsigned N_REQ = N_REQ_DEF,
  parameter  int unsigned IN_W  = IN_W_DEF,
  parameter  int unsigned OUT_W = OUT_W_DEF,
`ifdef SAT_STATS_EN
  parameter  int unsigned CNT_W = CNT_W_DEF,
`endif
  localparam int unsigned ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ-1:0][IN_W-1:0] req_data,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       out_valid,
  output logic [OUT_W-1:0]           out_data,
  output logic [ID_W-1:0]            out_id,
  output logic                       out_sat,
`ifdef SAT_STATS_EN
  input  logic                       sat_cnt_clr,
  output logic [CNT_W-1:0]           sat_cnt,
`endif
  input  logic                       out_ready
);

  out_state_e         state_q, state_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [OUT_W-1:0]   data_q, data_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic               sat_q, sat_d;

  logic               can_load;
  logic [N_REQ-1:0]   gnt;
  logic [ID_W-1:0]    gnt_idx;
  logic               gnt_any;
  sat_res_t           sel_res;

  // Register may take a new sample when empty or when the sink drains it this cycle.
  assign can_load = (state_q == EMPTY) || out_ready;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req_i     (req_valid),
    .en_i      (can_load && !rst),
    .ptr_i     (ptr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .gnt_any_o (gnt_any)
  );

  assign req_ready = gnt;
  assign sel_res   = sym_sat(32'($signed(req_data[gnt_idx])), OUT_W);

  // Next-state: load on grant, drain to EMPTY when accepted with nothing new.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    id_d    = id_q;
    sat_d   = sat_q;
    if (gnt_any) begin
      state_d = FULL;
      data_d  = OUT_W'(sel_res.val);
      id_d    = gnt_idx;
      sat_d   = sel_res.clip;
      ptr_d   = (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
    end else if (state_q == FULL && out_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      ptr_q   <= '0;
      data_q  <= '0;
      id_q    <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      id_q    <= id_d;
      sat_q   <= sat_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_data  = data_q;
  assign out_id    = id_q;
  assign out_sat   = sat_q;

`ifdef SAT_STATS_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Clip event counter: clear dominates, sticks at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (sat_cnt_clr) begin
      cnt_d = '0;
    end else if (gnt_any && sel_res.clip && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign sat_cnt = cnt_q;
`endif

endmodule
